// File: rtl/output_bram_writer_pkg.sv
// output_bram_writer_pkg: shared sizing, derived dimensions and state encoding for the output BRAM path
package output_bram_writer_pkg;
  localparam int DEF_WIDTH             = 16;
  localparam int DEF_BLOCK_SIZE        = 2;
  localparam int DEF_CHUNK_SIZE        = 4;
  localparam int DEF_W_OUTER_DIMENSION = 8;
  localparam int DEF_I_OUTER_DIMENSION = 4;
  localparam int DEF_ADDR_WIDTH        = 12;
  localparam int TILES_PER_WORD = DEF_CHUNK_SIZE / DEF_BLOCK_SIZE;
  localparam int WORDS_PER_ROW  = DEF_W_OUTER_DIMENSION / DEF_CHUNK_SIZE;
  localparam int ROW_SIZE_MAT_C = DEF_I_OUTER_DIMENSION / DEF_BLOCK_SIZE;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} wr_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/output_bram_writer_tile_row_buffer.sv
// tile_row_buffer: BLOCK_SIZE rows of CHUNK_SIZE elements, filled one tile-wide slot at a time
module tile_row_buffer
  import output_bram_writer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int CHUNK_SIZE = DEF_CHUNK_SIZE,
  parameter int SLOT_W     = idx_w(CHUNK_SIZE / BLOCK_SIZE),
  parameter int ROW_W      = idx_w(BLOCK_SIZE)
) (
  input  logic                                clk,
  input  logic                                i_wr_en,
  input  logic [SLOT_W-1:0]                   i_slot,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] i_tile,
  input  logic [ROW_W-1:0]                    i_row,
  output logic [WIDTH*CHUNK_SIZE-1:0]         o_word
);
  logic [WIDTH-1:0] r_buf [BLOCK_SIZE][CHUNK_SIZE];
  always_ff @(posedge clk)
    for (int i = 0; i < BLOCK_SIZE; i++)
      for (int k = 0; k < CHUNK_SIZE; k++)
        if (i_wr_en && i_slot == SLOT_W'(k / BLOCK_SIZE))
          r_buf[i][k] <= i_tile[(i*BLOCK_SIZE + k%BLOCK_SIZE)*WIDTH +: WIDTH];
  // the slot being written reads through from the incoming tile so a word can leave on the fill edge
  for (genvar k = 0; k < CHUNK_SIZE; k++) begin : g_rd
    assign o_word[k*WIDTH +: WIDTH] = (i_wr_en && i_slot == SLOT_W'(k / BLOCK_SIZE))
      ? i_tile[(int'(i_row)*BLOCK_SIZE + k%BLOCK_SIZE)*WIDTH +: WIDTH]
      : r_buf[i_row][k];
  end
endmodule

// File: rtl/output_bram_writer.sv
// output_bram_writer: re-packs result tiles into row-major CHUNK_SIZE-element words on BRAM port A
module output_bram_writer
  import output_bram_writer_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int BLOCK_SIZE        = DEF_BLOCK_SIZE,
  parameter int CHUNK_SIZE        = DEF_CHUNK_SIZE,
  parameter int W_OUTER_DIMENSION = DEF_W_OUTER_DIMENSION,
  parameter int I_OUTER_DIMENSION = DEF_I_OUTER_DIMENSION,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clr,
  input  logic                                   start,
  output logic                                   ready,
  output logic                                   done,
  input  logic                                   tile_valid,
  output logic                                   tile_ready,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] tile_data,
  output logic                                   out_ena,
  output logic [WIDTH*CHUNK_SIZE/8-1:0]          out_wea,
  output logic [ADDR_WIDTH-1:0]                  out_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]            out_dina
);
  localparam int TPW    = CHUNK_SIZE / BLOCK_SIZE;
  localparam int WPR    = W_OUTER_DIMENSION / CHUNK_SIZE;
  localparam int RSC    = I_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int SLOT_W = idx_w(TPW);
  localparam int ROW_W  = idx_w(BLOCK_SIZE);
  localparam int COL_W  = idx_w(WPR);
  localparam int TROW_W = idx_w(RSC);
  wr_state_t                   r_state;
  logic [SLOT_W-1:0]           r_slot;
  logic [ROW_W-1:0]            r_drain_row;
  logic [COL_W-1:0]            r_word_col;
  logic [TROW_W-1:0]           r_tile_row;
  logic [ROW_W-1:0]            w_rd_row;
  logic [ADDR_WIDTH-1:0]       w_base;
  logic [WIDTH*CHUNK_SIZE-1:0] w_rd_word;
  logic                        w_accept;
  logic                        w_last_slot;
  logic                        w_last_row;
  logic                        w_last_col;
  logic                        w_last_trow;
  assign w_accept    = (r_state == S_FILL) && tile_valid && tile_ready;
  assign w_last_slot = r_slot == SLOT_W'(TPW - 1);
  assign w_last_row  = r_drain_row == ROW_W'(BLOCK_SIZE - 1);
  assign w_last_col  = r_word_col == COL_W'(WPR - 1);
  assign w_last_trow = r_tile_row == TROW_W'(RSC - 1);
  // row 0 is fetched on the filling edge, later rows one ahead of the row on the bus
  assign w_rd_row    = (r_state == S_DRAIN) ? r_drain_row + ROW_W'(1) : '0;
  assign w_base      = ADDR_WIDTH'(int'(r_tile_row) * BLOCK_SIZE * WPR + int'(r_word_col));
  tile_row_buffer #(
    .WIDTH      (WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .CHUNK_SIZE (CHUNK_SIZE)
  ) u_buf (
    .clk     (clk),
    .i_wr_en (w_accept),
    .i_slot  (r_slot),
    .i_tile  (tile_data),
    .i_row   (w_rd_row),
    .o_word  (w_rd_word)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_slot      <= '0;
      r_drain_row <= '0;
      r_word_col  <= '0;
      r_tile_row  <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      tile_ready  <= 1'b0;
      out_ena     <= 1'b0;
      out_wea     <= '0;
      out_addra   <= '0;
      out_dina    <= '0;
    end else if (clr) begin
      r_state     <= S_IDLE;
      r_slot      <= '0;
      r_drain_row <= '0;
      r_word_col  <= '0;
      r_tile_row  <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      tile_ready  <= 1'b0;
      out_ena     <= 1'b0;
      out_wea     <= '0;
      out_addra   <= '0;
      out_dina    <= '0;
    end else
      case (r_state)
        S_IDLE:
          if (start) begin
            r_state     <= S_FILL;
            r_slot      <= '0;
            r_drain_row <= '0;
            r_word_col  <= '0;
            r_tile_row  <= '0;
            ready       <= 1'b0;
            tile_ready  <= 1'b1;
          end
        S_FILL:
          if (w_accept) begin
            if (w_last_slot) begin
              r_state     <= S_DRAIN;
              r_slot      <= '0;
              r_drain_row <= '0;
              tile_ready  <= 1'b0;
              out_ena     <= 1'b1;
              out_wea     <= '1;
              out_addra   <= w_base;
              out_dina    <= w_rd_word;
            end else
              r_slot <= r_slot + SLOT_W'(1);
          end
        S_DRAIN:
          if (w_last_row) begin
            out_ena <= 1'b0;
            out_wea <= '0;
            if (w_last_col && w_last_trow) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state    <= S_FILL;
              tile_ready <= 1'b1;
              r_word_col <= w_last_col ? '0 : r_word_col + COL_W'(1);
              r_tile_row <= w_last_col ? r_tile_row + TROW_W'(1) : r_tile_row;
            end
          end else begin
            r_drain_row <= r_drain_row + ROW_W'(1);
            out_addra   <= out_addra + ADDR_WIDTH'(WPR);
            out_dina    <= w_rd_word;
          end
        default: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
endmodule

// File: tb/tb_output_bram_writer.sv
// tb_output_bram_writer: scoreboard bench for the 4x8 default output writer
module tb_output_bram_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        tile_valid = 1'b0;
  logic [63:0] tile_data = '0;
  logic        ready, done, tile_ready, out_ena;
  logic [7:0]  out_wea;
  logic [11:0] out_addra;
  logic [63:0] out_dina;

  output_bram_writer dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .ready(ready), .done(done),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .out_ena(out_ena), .out_wea(out_wea), .out_addra(out_addra), .out_dina(out_dina)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [11:0] a; logic [63:0] d;} exp_t;
  exp_t exp_q[$];
  exp_t m_e;
  int   n_chk = 0, n_fail = 0, n_wr = 0, n_done = 0;
  logic prev_done = 1'b0;
  int   ord[8] = '{0, 2, 1, 3, 4, 6, 5, 7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mk_tile(input int base, input int t);
    logic [63:0] d = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        d[(i*2+j)*16 +: 16] = 16'(base + 16*t + 2*i + j);
    return d;
  endfunction

  // element (r,c) of C lives in tile (r/2)*4 + c/2 at position (r%2, c%2)
  function automatic logic [63:0] model(input int base, input int a);
    logic [63:0] w = '0;
    int r = a / 2;
    int wc = a % 2;
    for (int k = 0; k < 4; k++) begin
      int c = wc*4 + k;
      int t = (r/2)*4 + c/2;
      w[k*16 +: 16] = 16'(base + 16*t + 2*(r%2) + (c%2));
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (out_ena) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", out_addra, out_dina);
      end else begin
        m_e = exp_q.pop_front();
        chk("write_addr", 64'(out_addra), 64'(m_e.a));
        chk("write_data", out_dina, m_e.d);
        chk("write_wea", 64'(out_wea), 64'hFF);
      end
    end
    if (done) begin
      n_done++;
      chk("done_single_cycle", 64'(prev_done), 64'd0);
    end
    prev_done = done;
  end

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic send_tile(input int base, input int t, input int gap, output int stalls);
    repeat (gap) begin @(posedge clk); #1; end
    tile_valid = 1'b1;
    tile_data  = mk_tile(base, t);
    stalls = 0;
    @(negedge clk);
    while (!tile_ready && stalls < 20) begin stalls++; @(negedge clk); end
    if (!tile_ready) chk("tile_ready_timeout", 64'(tile_ready), 64'd1);
    @(posedge clk) #1 tile_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 60) begin n++; @(negedge clk); end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_matrix(input int bubbles, input int literal);
    int st;
    int d0 = n_done;
    int w0 = n_wr;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.a = 12'(ord[i]);
      e.d = model(0, ord[i]);
      if (literal && ord[i] == 0) e.d = 64'h0011_0010_0001_0000;
      if (literal && ord[i] == 2) e.d = 64'h0013_0012_0003_0002;
      exp_q.push_back(e);
    end
    do_start();
    chk("ready_after_start", 64'(ready), 64'd0);
    for (int t = 0; t < 8; t++) begin
      if (bubbles && t == 5) begin
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
      end
      send_tile(0, t, bubbles ? int'($urandom_range(0, 3)) : 0, st);
      if (!bubbles && t == 2) chk("drain_backpressure_cycles", 64'(st), 64'd2);
    end
    wait_done();
    repeat (3) @(negedge clk);
    chk("writes_per_matrix", 64'(n_wr - w0), 64'd8);
    chk("done_pulses", 64'(n_done - d0), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("ready_after_done", 64'(ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, d0;
    exp_t e;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tile_ready", 64'(tile_ready), 64'd0);
    chk("rst_out_ena", 64'(out_ena), 64'd0);
    chk("rst_out_wea", 64'(out_wea), 64'd0);
    chk("rst_out_addra", 64'(out_addra), 64'd0);
    chk("rst_out_dina", out_dina, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_matrix(0, 1);

    // async reset in the middle of a drain
    d0 = n_done;
    do_start();
    send_tile(0, 0, 0, st);
    send_tile(0, 1, 0, st);
    chk("drain_ena_before_reset", 64'(out_ena), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_ena_immediate", 64'(out_ena), 64'd0);
    chk("reset_ready_immediate", 64'(ready), 64'd1);
    chk("reset_tile_ready", 64'(tile_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_no_done", 64'(n_done - d0), 64'd0);

    run_matrix(1, 0);

    // abort after three tiles: only group 0 of the aborted run reaches the BRAM
    d0 = n_done;
    e.a = 12'd0; e.d = model(100, 0); exp_q.push_back(e);
    e.a = 12'd2; e.d = model(100, 2); exp_q.push_back(e);
    do_start();
    for (int t = 0; t < 3; t++) send_tile(100, t, 0, st);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    chk("clr_ready", 64'(ready), 64'd1);
    chk("clr_tile_ready", 64'(tile_ready), 64'd0);
    @(negedge clk) begin clr = 1'b1; start = 1'b1; end
    @(negedge clk) begin clr = 1'b0; start = 1'b0; end
    chk("clr_beats_start_ready", 64'(ready), 64'd1);
    chk("clr_beats_start_tile_ready", 64'(tile_ready), 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", 64'(n_done - d0), 64'd0);
    chk("abort_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    run_matrix(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
